// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Bundles the requester handshake, the baud-generator handshake and the
// serial output of uart_tx_sched.
//   req0/data0/ack0  requester 0: level request, byte, one-cycle capture ack
//   req1/data1/ack1  requester 1: same as requester 0
//   clk_bps          one-cycle bit-period pulse from bps_module
//   count_sig        enable to bps_module (its counter restarts while low)
//   tx               serial line, idle high
//   busy             high while a frame is in progress
// Modports: slave = the scheduler, master = sources/baud generator/observer.
interface uart_tx_sched_if #(
  parameter int DATA_BITS = 8
);
  logic                 req0;
  logic [DATA_BITS-1:0] data0;
  logic                 ack0;
  logic                 req1;
  logic [DATA_BITS-1:0] data1;
  logic                 ack1;
  logic                 clk_bps;
  logic                 count_sig;
  logic                 tx;
  logic                 busy;

  modport slave (
    input  req0, data0, req1, data1, clk_bps,
    output ack0, ack1, count_sig, tx, busy
  );

  modport master (
    output req0, data0, req1, data1, clk_bps,
    input  ack0, ack1, count_sig, tx, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler for two byte sources feeding one UART transmitter.
// The winning byte is sent as start bit, DATA_BITS data bits (LSB first) and
// STOP_BITS stop bits, one bit per clk_bps pulse from the shared bps_module,
// whose counter is enabled through count_sig.
// Ports:
//   sysclk  system clock, rising edge
//   rst     asynchronous active-high reset
//   bus     uart_tx_sched_if.slave (requests, acks, clk_bps, count_sig, tx, busy)
// Parameters:
//   DATA_BITS  data bits per frame, 5..8
//   STOP_BITS  stop bits per frame, 1 or 2
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            sysclk,
  input  logic            rst,
  uart_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state_r, state_s;
  logic                 ptr_r, ptr_s;          // last granted requester
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [2:0]           bitcnt_r, bitcnt_s;
  logic [0:0]           stopcnt_r, stopcnt_s;
  logic                 tx_r, tx_s;
  logic                 count_sig_r, count_sig_s;
  logic                 ack0_r, ack0_s;
  logic                 ack1_r, ack1_s;
  logic                 busy_r, busy_s;
  logic                 grant0_s;

  // Next-state, datapath and output decode for the frame sequencer.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    shift_s     = shift_r;
    bitcnt_s    = bitcnt_r;
    stopcnt_s   = stopcnt_r;
    tx_s        = tx_r;
    count_sig_s = count_sig_r;
    ack0_s      = 1'b0;
    ack1_s      = 1'b0;
    busy_s      = 1'b0;
    // Requester 0 wins alone, or on a tie when requester 1 was granted last.
    grant0_s    = bus.req0 & (~bus.req1 | ptr_r);

    case (state_r)
      IDLE: begin
        // clk_bps is deliberately ignored here; count_sig low restarts bps_module.
        tx_s        = 1'b1;
        count_sig_s = 1'b0;
        if (bus.req0 | bus.req1) begin
          state_s     = START;
          tx_s        = 1'b0;
          count_sig_s = 1'b1;
          if (grant0_s) begin
            shift_s = bus.data0;
            ack0_s  = 1'b1;
            ptr_s   = 1'b0;
          end else begin
            shift_s = bus.data1;
            ack1_s  = 1'b1;
            ptr_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bus.clk_bps) begin
          tx_s     = shift_r[0];
          shift_s  = {1'b0, shift_r[DATA_BITS-1:1]};
          bitcnt_s = 3'd0;
          state_s  = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bus.clk_bps) begin
          if (bitcnt_r == LAST_BIT) begin
            tx_s      = 1'b1;
            stopcnt_s = 1'b0;
            state_s   = STOP;
          end else begin
            tx_s     = shift_r[0];
            shift_s  = {1'b0, shift_r[DATA_BITS-1:1]};
            bitcnt_s = bitcnt_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (bus.clk_bps) begin
          if (stopcnt_r == LAST_STOP) begin
            count_sig_s = 1'b0;
            state_s     = IDLE;
          end else begin
            stopcnt_s = stopcnt_r + 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s     = IDLE;
        tx_s        = 1'b1;
        count_sig_s = 1'b0;
      end
    endcase

    // busy is registered from the next state so it tracks state != IDLE.
    busy_s = (state_s != IDLE);
  end

  // State, datapath and registered outputs; reset abandons any frame.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b1;
      shift_r     <= '0;
      bitcnt_r    <= 3'd0;
      stopcnt_r   <= 1'b0;
      tx_r        <= 1'b1;
      count_sig_r <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      shift_r     <= shift_s;
      bitcnt_r    <= bitcnt_s;
      stopcnt_r   <= stopcnt_s;
      tx_r        <= tx_s;
      count_sig_r <= count_sig_s;
      ack0_r      <= ack0_s;
      ack1_r      <= ack1_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.tx        = tx_r;
  assign bus.count_sig = count_sig_r;
  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Directed bench for uart_tx_sched: an 8N1 instance (dut1) and an 8N2
// instance (dut2), each with a bps_module model that pulses clk_bps every
// 16 sysclk cycles while count_sig is high. Outputs are sampled on the
// falling edge; tx is captured at each clk_bps pulse, i.e. at the end of
// every bit slot, and compared against hand-built frames.
module tb_uart_tx_sched;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  logic force_pulse = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_sched_if #(.DATA_BITS(8)) if1 ();
  uart_tx_sched_if #(.DATA_BITS(8)) if2 ();

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (if1.slave)
  );

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (if2.slave)
  );

  // bps_module models
  logic [3:0] bps1_cnt = 4'd0;
  logic       bps1_pulse = 1'b0;
  logic [3:0] bps2_cnt = 4'd0;
  logic       bps2_pulse = 1'b0;

  always @(posedge sysclk) begin
    if (!if1.count_sig) begin
      bps1_cnt <= 4'd0; bps1_pulse <= 1'b0;
    end else if (bps1_cnt == 4'd15) begin
      bps1_cnt <= 4'd0; bps1_pulse <= 1'b1;
    end else begin
      bps1_cnt <= bps1_cnt + 4'd1; bps1_pulse <= 1'b0;
    end
  end

  always @(posedge sysclk) begin
    if (!if2.count_sig) begin
      bps2_cnt <= 4'd0; bps2_pulse <= 1'b0;
    end else if (bps2_cnt == 4'd15) begin
      bps2_cnt <= 4'd0; bps2_pulse <= 1'b1;
    end else begin
      bps2_cnt <= bps2_cnt + 4'd1; bps2_pulse <= 1'b0;
    end
  end

  assign if1.clk_bps = bps1_pulse | force_pulse;
  assign if2.clk_bps = bps2_pulse | force_pulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Capture tx at each clk_bps pulse until count_sig drops (ends on the first
  // falling edge that sees count_sig low, i.e. in the IDLE cycle).
  task automatic run_frame(input bit sel, output logic [15:0] bits, output int npulses);
    bit done = 1'b0;
    bits = '0;
    npulses = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge sysclk);
      if (!(sel ? if2.count_sig : if1.count_sig)) begin
        done = 1'b1;
      end else if (sel ? if2.clk_bps : if1.clk_bps) begin
        if (npulses < 16) bits[npulses] = sel ? if2.tx : if1.tx;
        npulses++;
      end
    end
    chk("frame_end_seen", 32'(done), 32'd1);
  endtask

  // Wait for either ack; who = 0 or 1 (2 on timeout).
  task automatic wait_ack(input bit sel, output int who);
    who = 2;
    for (int i = 0; i < 8 && who == 2; i++) begin
      @(negedge sysclk);
      if (sel ? if2.ack0 : if1.ack0) who = 0;
      else if (sel ? if2.ack1 : if1.ack1) who = 1;
    end
    if (who == 2) chk("ack_timeout", 32'(who), 32'd0);
  endtask

  logic [15:0] bits;
  int          np;
  int          who;
  int          idle_bad;
  bit          got_pulses;

  initial begin
    if1.req0 = 1'b0; if1.req1 = 1'b0; if1.data0 = 8'h00; if1.data1 = 8'h00;
    if2.req0 = 1'b0; if2.req1 = 1'b0; if2.data0 = 8'h00; if2.data1 = 8'h00;

    // 1. reset values, held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      chk("rst_tx",   32'(if1.tx),        32'd1);
      chk("rst_cs",   32'(if1.count_sig), 32'd0);
      chk("rst_acks", 32'({if1.ack0, if1.ack1}), 32'd0);
      chk("rst_busy", 32'(if1.busy),      32'd0);
    end
    rst = 1'b0;

    // 6a. spurious clk_bps in IDLE changes nothing
    @(negedge sysclk);
    force_pulse = 1'b1;
    @(negedge sysclk);
    force_pulse = 1'b0;
    chk("spur_outs", 32'({if1.tx, if1.count_sig, if1.busy, if1.ack0, if1.ack1}), 32'b10000);
    @(negedge sysclk);
    chk("spur_outs2", 32'({if1.tx, if1.count_sig, if1.busy}), 32'b100);

    // 2. single frame 8'h55 from requester 0
    if1.req0 = 1'b1; if1.data0 = 8'h55;
    @(negedge sysclk);
    chk("f55_grant", 32'({if1.ack0, if1.ack1, if1.tx, if1.count_sig, if1.busy}), 32'b10011);
    if1.req0 = 1'b0;
    @(negedge sysclk);
    chk("f55_ack_once", 32'(if1.ack0), 32'd0);
    run_frame(1'b0, bits, np);
    chk("f55_pulses", 32'(np), 32'd10);
    chk("f55_bits", 32'(bits[9:0]), 32'({1'b1, 8'h55, 1'b0}));
    chk("f55_after", 32'({if1.tx, if1.count_sig, if1.busy}), 32'b100);

    // 3. simultaneous requests after a fresh reset: requester 0 first
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    if1.req0 = 1'b1; if1.data0 = 8'hA5;
    if1.req1 = 1'b1; if1.data1 = 8'h3C;
    @(negedge sysclk);
    chk("tie_acks", 32'({if1.ack0, if1.ack1}), 32'b10);
    if1.req0 = 1'b0;
    run_frame(1'b0, bits, np);
    chk("fA5_pulses", 32'(np), 32'd10);
    chk("fA5_bits", 32'(bits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
    chk("gap_cycle", 32'({if1.tx, if1.count_sig, if1.ack1}), 32'b100);
    @(negedge sysclk);
    chk("f3C_grant", 32'({if1.ack1, if1.count_sig, if1.tx}), 32'b110);
    if1.req1 = 1'b0;
    run_frame(1'b0, bits, np);
    chk("f3C_pulses", 32'(np), 32'd10);
    chk("f3C_bits", 32'(bits[9:0]), 32'({1'b1, 8'h3C, 1'b0}));

    // 4. fairness: both held for 4 frames (last grant was 1)
    if1.req0 = 1'b1; if1.data0 = 8'h11;
    if1.req1 = 1'b1; if1.data1 = 8'h22;
    for (int f = 0; f < 4; f++) begin
      wait_ack(1'b0, who);
      chk($sformatf("fair_grant%0d", f), 32'(who), 32'(f % 2));
      if (f == 3) begin
        if1.req0 = 1'b0; if1.req1 = 1'b0;
      end
      run_frame(1'b0, bits, np);
      chk($sformatf("fair_bits%0d", f), 32'(bits[9:0]),
          (f % 2 == 0) ? 32'({1'b1, 8'h11, 1'b0}) : 32'({1'b1, 8'h22, 1'b0}));
    end

    // 5. reset during data bit 3 of 8'h00
    if1.req0 = 1'b1; if1.data0 = 8'h00;
    wait_ack(1'b0, who);
    chk("f00_who", 32'(who), 32'd0);
    if1.req0 = 1'b0;
    np = 0;
    got_pulses = 1'b0;
    for (int i = 0; i < 200 && !got_pulses; i++) begin
      @(negedge sysclk);
      if (if1.clk_bps) np++;
      if (np == 4) got_pulses = 1'b1;
    end
    chk("f00_reach_bit3", 32'(got_pulses), 32'd1);
    repeat (8) @(negedge sysclk);
    chk("f00_bit3", 32'({if1.tx, if1.count_sig, if1.busy}), 32'b011);
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({if1.tx, if1.count_sig, if1.busy, if1.ack0, if1.ack1}), 32'b10000);
    @(negedge sysclk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (if1.count_sig || if1.busy || !if1.tx || if1.ack0 || if1.ack1) idle_bad++;
    end
    chk("post_rst_idle", 32'(idle_bad), 32'd0);
    if1.req1 = 1'b1; if1.data1 = 8'h96;
    wait_ack(1'b0, who);
    chk("f96_who", 32'(who), 32'd1);
    if1.req1 = 1'b0;
    run_frame(1'b0, bits, np);
    chk("f96_pulses", 32'(np), 32'd10);
    chk("f96_bits", 32'(bits[9:0]), 32'({1'b1, 8'h96, 1'b0}));

    // 6b. two stop bits
    if2.req0 = 1'b1; if2.data0 = 8'hC3;
    wait_ack(1'b1, who);
    chk("fC3_who", 32'(who), 32'd0);
    if2.req0 = 1'b0;
    run_frame(1'b1, bits, np);
    chk("fC3_pulses", 32'(np), 32'd11);
    chk("fC3_bits", 32'(bits[10:0]), 32'({2'b11, 8'hC3, 1'b0}));
    chk("fC3_after", 32'({if2.tx, if2.count_sig, if2.busy}), 32'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
